// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the mandelbrot pixel sink.
//   COLOR_W       : width of an RGB888 pixel
//   rgb_t         : packed {r,g,b} pixel
//   BLACK         : colour of points inside the set
//   sink_state_t  : sink control states IDLE / RUN / DONE
//   grey_colour() : iteration count -> grey ramp pixel
package mandelbrot_pkg;

    localparam int COLOR_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_t;

    // Grey level is i scaled by the integer step 255/imax; the product is
    // deliberately truncated to 8 bits.
    function automatic rgb_t grey_colour(input logic [15:0] i, input int unsigned imax);
        logic [23:0] prod;
        logic [7:0]  g;
        prod = 24'(i) * 24'(255 / imax);
        g    = prod[7:0];
        return '{r: g, g: g, b: g};
    endfunction

endpackage

// File: rtl/mandelbrot_pixel_sink_if.sv
// Pixel input strobe and framebuffer write port of the mandelbrot pixel sink.
//   in_valid/in_x/in_y/in_i : pixel result from the core (no back-pressure)
//   fb_we/fb_ready          : framebuffer write valid/ready handshake
//   fb_addr/fb_data         : linear address and RGB888 data of the write
// master = pixel source / framebuffer side, slave = the sink.
interface mandelbrot_pixel_sink_if #(
    parameter int AW = 22
);
    logic          in_valid;
    logic [10:0]   in_x;
    logic [10:0]   in_y;
    logic [15:0]   in_i;
    logic          fb_we;
    logic          fb_ready;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_data;

    modport master (
        output in_valid, in_x, in_y, in_i, fb_ready,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_i, fb_ready,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/mandelbrot_sink_fifo.sv
// Synchronous write buffer for {address, colour} entries.
//   push/wdata : enqueue; a push into a full FIFO only lands if pop is
//                also asserted that cycle, otherwise it is discarded
//   pop/rdata  : dequeue; rdata is the current head
//   empty      : no entries
//   count      : number of entries held (0..DEPTH)
// Pointers carry one extra wrap bit to tell full from empty.
module mandelbrot_sink_fifo #(
    parameter int DW    = 46,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wptr;
    logic [PW:0]   rptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= wdata;
    end
endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// Mandelbrot pixel sink: consumes {x,y,i} results from the core, colours
// them, buffers them and writes them to a framebuffer port.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a frame (honoured in IDLE/DONE only)
//   bus         : pixel input strobe + framebuffer write handshake (slave)
//   busy        : frame in progress
//   frame_done  : RESX*RESY writes completed
//   overflow    : sticky, a pixel was lost because the buffer was full
//   range_err   : sticky, an out-of-frame pixel was discarded
//   pix_count   : framebuffer writes completed in the current frame
// Optional feature: define MANDELBROT_SINK_PALETTE_EN to add a writable
// 16-entry palette (pal_we/pal_idx/pal_data) in place of the grey ramp.
module mandelbrot_pixel_sink
    import mandelbrot_pkg::*;
#(
    parameter int RESX       = 640,
    parameter int RESY       = 480,
    parameter int IMAX       = 15,
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    mandelbrot_pixel_sink_if.slave  bus,
`ifdef MANDELBROT_SINK_PALETTE_EN
    input  logic                    pal_we,
    input  logic [3:0]              pal_idx,
    input  logic [23:0]             pal_data,
`endif
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow,
    output logic                    range_err,
    output logic [AW-1:0]           pix_count
);
    localparam int          CW       = $clog2(FIFO_DEPTH);
    localparam int          ADDR_W   = 23;
    localparam logic [11:0] RESX_L   = 12'(RESX);
    localparam logic [11:0] RESY_L   = 12'(RESY);
    localparam logic [16:0] IMAX_L   = 17'(IMAX);
    localparam logic [AW-1:0] LAST_PIX = AW'(RESX * RESY - 1);

    sink_state_t state;
    sink_state_t state_nxt;

    logic               start_acc;
    logic               accept_in;
    logic               in_range;
    logic [ADDR_W-1:0]  lin_addr;
    rgb_t               colour_in;

    logic               vld_p1;
    logic [AW-1:0]      addr_p1;
    rgb_t               colour_p1;

    logic [AW+COLOR_W-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic [CW:0]           fifo_count;
    logic                  fifo_pop;
    logic                  drop;

    assign start_acc = start && (state != RUN);
    assign accept_in = bus.in_valid && (state == RUN);
    assign in_range  = ({1'b0, bus.in_x} < RESX_L) && ({1'b0, bus.in_y} < RESY_L);
    assign lin_addr  = ADDR_W'(bus.in_y) * ADDR_W'(RESX) + ADDR_W'(bus.in_x);

`ifdef MANDELBROT_SINK_PALETTE_EN
    rgb_t pal [16];

    // Reset contents reproduce the grey ramp; a write and a lookup of the
    // same entry in one cycle sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                pal[k] <= rgb_t'({3{8'(17 * k)}});
            end
        end else if (pal_we) begin
            pal[pal_idx] <= rgb_t'(pal_data);
        end
    end

    assign colour_in = ({1'b0, bus.in_i} >= IMAX_L) ? BLACK : pal[bus.in_i[3:0]];
`else
    assign colour_in = ({1'b0, bus.in_i} >= IMAX_L) ? BLACK
                                                    : grey_colour(bus.in_i, IMAX);
`endif

    // ---- S1: range check, address and colour ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept_in && in_range;
    end

    always_ff @(posedge clk) begin
        if (accept_in && in_range) begin
            addr_p1   <= AW'(lin_addr);
            colour_p1 <= colour_in;
        end
    end

    // ---- FIFO: S1 push, framebuffer pop ----
    assign fifo_pop = !fifo_empty && bus.fb_ready;
    // The core cannot be stalled, so a full buffer with no pop loses the pixel.
    assign drop     = vld_p1 && (fifo_count == (CW+1)'(FIFO_DEPTH)) && !fifo_pop;

    mandelbrot_sink_fifo #(
        .DW    (AW + COLOR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p1),
        .pop   (fifo_pop),
        .wdata ({addr_p1, colour_p1}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs are forced to zero while empty so stale buffer contents
    // never appear on the bus.
    assign bus.fb_we   = !fifo_empty;
    assign bus.fb_addr = fifo_empty ? '0 : fifo_rdata[AW+COLOR_W-1:COLOR_W];
    assign bus.fb_data = fifo_empty ? '0 : fifo_rdata[COLOR_W-1:0];

    // ---- Counters and sticky flags ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else if (start_acc) begin
            pix_count <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (fifo_pop && (state == RUN)) pix_count <= pix_count + 1'b1;
            if (drop)                       overflow  <= 1'b1;
            if (accept_in && !in_range)     range_err <= 1'b1;
        end
    end

    // ---- Frame control ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // DONE is reached the cycle after the final write is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (fifo_pop && (pix_count == LAST_PIX)) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state == RUN);
    assign frame_done = (state == DONE);
endmodule
